// File: rtl/gemm_tile_sequencer_if.sv
// -----------------------------------------------------------------------------
// gemm_tile_sequencer_if
//
// Purpose:
//   Result stream between the GEMM tile sequencer and whatever consumes the
//   finished dot products. The stream uses a valid/ready handshake, and each
//   beat carries the result together with its (row, col) coordinate in the
//   output tile.
//
// Signals:
//   outValid  master -> slave  a result is presented
//   outReady  slave  -> master consumer accepts the presented result
//   outData   master -> slave  result value
//   outRow    master -> slave  tile row of the result
//   outCol    master -> slave  tile column of the result
// -----------------------------------------------------------------------------
interface gemm_tile_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 8
);
    logic                  outValid;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] outData;
    logic [DIM_WIDTH-1:0]  outRow;
    logic [DIM_WIDTH-1:0]  outCol;

    // The sequencer produces results (master); the consumer accepts them (slave).
    modport master (output outValid, output outData, output outRow, output outCol,
                    input  outReady);
    modport slave  (input  outValid, input  outData, input  outRow, input  outCol,
                    output outReady);
endinterface

// File: rtl/gemm_tile_sequencer.sv
// -----------------------------------------------------------------------------
// gemm_tile_sequencer
//
// Purpose:
//   This block steps the inner-product datapath across an M x N output tile in
//   row-major order. It issues operand-buffer reads and follows each result
//   through the fixed-latency datapath with a tag shift register. Finished
//   results go into a local FIFO, which feeds a valid/ready result port. The
//   datapath cannot stall, so issue is limited by credit: the in-flight tags
//   plus the FIFO occupancy never exceed FIFO_DEPTH.
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-low reset
//   start_i        begin a tile (only looked at in IDLE)
//   mRows_i        tile rows, latched on accepted start
//   nCols_i        tile columns, latched on accepted start
//   busy_o         high in every state except IDLE
//   done_o         one-cycle pulse when the tile completes
//   aRdEn_o        A-row buffer read strobe
//   aRdAddr_o      A-row index
//   bRdEn_o        B-column buffer read strobe (same as aRdEn_o)
//   bRdAddr_o      B-column index
//   ipuDataOut_i   datapath result, aligned with the last tag stage
//   stallCycles_o  RUN cycles without an issue (SEQ_PERF_CNT_EN builds only)
//   res            result stream (gemm_tile_sequencer_if.master)
//
// Configuration macro:
//   SEQ_PERF_CNT_EN  adds the stallCycles_o port and its saturating counter
// -----------------------------------------------------------------------------
module gemm_tile_sequencer #(
    parameter int VECTOR_LEN   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int PIPE_LATENCY = $clog2(VECTOR_LEN),
    parameter int DIM_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DIM_WIDTH-1:0]  mRows_i,
    input  logic [DIM_WIDTH-1:0]  nCols_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aRdEn_o,
    output logic [DIM_WIDTH-1:0]  aRdAddr_o,
    output logic                  bRdEn_o,
    output logic [DIM_WIDTH-1:0]  bRdAddr_o,
    input  logic [DATA_WIDTH-1:0] ipuDataOut_i,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]           stallCycles_o,
`endif
    gemm_tile_sequencer_if.master res
);

    localparam int NSTAGE = PIPE_LATENCY + 1;
    localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W  = $clog2(NSTAGE + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DIM_WIDTH-1:0]   mRows_q, nCols_q;
    logic [DIM_WIDTH-1:0]   rowIdx_q, colIdx_q;

    logic [NSTAGE-1:0]      stgValid_q;
    logic [DIM_WIDTH-1:0]   stgRow_q [NSTAGE];
    logic [DIM_WIDTH-1:0]   stgCol_q [NSTAGE];

    logic [DATA_WIDTH-1:0]  fifoData_q [FIFO_DEPTH];
    logic [DIM_WIDTH-1:0]   fifoRow_q  [FIFO_DEPTH];
    logic [DIM_WIDTH-1:0]   fifoCol_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0]      wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]       fifoCount_q, fifoCount_d;

    logic [INF_W-1:0]       inflight;
    logic                   hasCredit, issue, colLast, lastIssue, startAccept;
    logic                   push, pop, fifoFull;

    // The credit check uses the registered FIFO count only. A pop in this
    // cycle frees its slot for the next cycle, not this one. Every issued tag
    // already owns a FIFO slot, so a push can never find the FIFO full.
    assign hasCredit   = (32'(inflight) + 32'(fifoCount_q)) < 32'(FIFO_DEPTH);
    assign issue       = (state_q == RUN) && hasCredit;
    assign colLast     = (colIdx_q == nCols_q - DIM_WIDTH'(1));
    assign lastIssue   = issue && colLast && (rowIdx_q == mRows_q - DIM_WIDTH'(1));
    assign startAccept = (state_q == IDLE) && start_i;

    assign push     = stgValid_q[NSTAGE-1];
    assign pop      = res.outValid && res.outReady;
    assign fifoFull = (fifoCount_q == CNT_W'(FIFO_DEPTH));

    // The number of in-flight tags is the number of valid stages in the tag
    // shift register, counting the one about to push into the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            inflight = inflight + INF_W'(stgValid_q[i]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. DRAIN looks at the FIFO count after this cycle's pop.
    // That lets done follow the final pop by exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (mRows_i == '0 || nCols_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (lastIssue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0 && fifoCount_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs. The read addresses are forced to zero when no issue
    // happens, so the operand buffers only see a meaningful index with a strobe.
    always_comb begin
        busy_o    = (state_q != IDLE);
        done_o    = (state_q == DONE);
        aRdEn_o   = issue;
        bRdEn_o   = issue;
        aRdAddr_o = issue ? rowIdx_q : '0;
        bRdAddr_o = issue ? colIdx_q : '0;
    end

    // Tile dimensions and the row-major walk. A start that is not accepted
    // leaves everything untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mRows_q  <= '0;
            nCols_q  <= '0;
            rowIdx_q <= '0;
            colIdx_q <= '0;
        end else if (startAccept) begin
            mRows_q  <= mRows_i;
            nCols_q  <= nCols_i;
            rowIdx_q <= '0;
            colIdx_q <= '0;
        end else if (issue) begin
            if (colLast) begin
                colIdx_q <= '0;
                rowIdx_q <= rowIdx_q + DIM_WIDTH'(1);
            end else begin
                colIdx_q <= colIdx_q + DIM_WIDTH'(1);
            end
        end
    end

    // Tag pipeline. Each issue enters stage 0 and moves one stage per cycle,
    // so the final stage lines up with the datapath result. Reset drops every
    // tag, which means results still in the datapath are never pushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stgValid_q <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                stgRow_q[i] <= '0;
                stgCol_q[i] <= '0;
            end
        end else begin
            stgValid_q[0] <= issue;
            stgRow_q[0]   <= rowIdx_q;
            stgCol_q[0]   <= colIdx_q;
            for (int i = 1; i < NSTAGE; i++) begin
                stgValid_q[i] <= stgValid_q[i-1];
                stgRow_q[i]   <= stgRow_q[i-1];
                stgCol_q[i]   <= stgCol_q[i-1];
            end
        end
    end

    // Next FIFO occupancy. A simultaneous push and pop leaves it unchanged.
    always_comb begin
        fifoCount_d = fifoCount_q;
        if (push && !pop) begin
            fifoCount_d = fifoCount_q + CNT_W'(1);
        end else if (pop && !push) begin
            fifoCount_d = fifoCount_q - CNT_W'(1);
        end
    end

    // Result FIFO storage and pointers. The depth is a power of two, so the
    // pointers simply wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoData_q[i] <= '0;
                fifoRow_q[i]  <= '0;
                fifoCol_q[i]  <= '0;
            end
        end else begin
            fifoCount_q <= fifoCount_d;
            if (push) begin
                fifoData_q[wrPtr_q] <= ipuDataOut_i;
                fifoRow_q[wrPtr_q]  <= stgRow_q[NSTAGE-1];
                fifoCol_q[wrPtr_q]  <= stgCol_q[NSTAGE-1];
                wrPtr_q             <= wrPtr_q + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + ADDR_W'(1);
            end
        end
    end

    // The output port shows the FIFO head entry straight from its registers.
    always_comb begin
        res.outValid = (fifoCount_q != '0);
        res.outData  = fifoData_q[rdPtr_q];
        res.outRow   = fifoRow_q[rdPtr_q];
        res.outCol   = fifoCol_q[rdPtr_q];
    end

    // Credit accounting should make an overflow impossible. This catches it
    // if it ever happens.
    noOverflow: assert property (@(posedge clk) disable iff (!rst)
                                 !(push && !pop && fifoFull));

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] stallCnt_q;

    // Counts RUN cycles in which credit blocked an issue. It clears on an
    // accepted start and stops at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt_q <= '0;
        end else if (startAccept) begin
            stallCnt_q <= '0;
        end else if (state_q == RUN && !issue && stallCnt_q != '1) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign stallCycles_o = stallCnt_q;
`endif

endmodule
